panel_loader_seq: RTL and testbench

- Synthesizable front-panel load/run sequencer. It replaces hand-timed Load PC / Deposit button sequences with a streamed, parametrised engine.
- Accepts {address, data} words over a valid/ready stream and drives the Front_Panel switch and button inputs to deposit each word. It then loads the start PC, sets the run switch and reports completion when the CPU halts.
- Improvements over hand sequencing: skips the Load PC step for sequential addresses, exploiting the panel's deposit auto-increment; all timing is configurable.

---
 rtl/panel_loader_seq.sv | 193 +++++++++++++++++++
 tb/tb_panel_loader_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_loader_seq.sv
// Front-panel load/run sequencer: deposits a streamed {addr,data} image, loads START_ADDR, runs, reports halt.
// Optional read-back check through the Examine button when PANEL_LOADER_VERIFY_EN is defined.
module panel_loader_seq #(
    parameter int          WORD_W     = 12,
    parameter int          SETUP_CYC  = 10,
    parameter int          PULSE_CYC  = 10,
    parameter int          SETTLE_CYC = 30,
    parameter int unsigned START_ADDR = 'o200
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [WORD_W-1:0] s_addr_i,
    input  logic [WORD_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic [WORD_W:0]   sw_o,
    output logic              btnl_o,
    output logic              btnd_o,
    input  logic              run_led_i,
    output logic              busy_o,
    output logic              done_o,
`ifdef PANEL_LOADER_VERIFY_EN
    output logic              btnc_o,
    input  logic [WORD_W-1:0] led_data_i,
    output logic              err_mismatch_o,
`endif
    output logic [WORD_W:0]   words_loaded_o
);

    localparam int CW = 16;
    localparam logic [CW-1:0]     SETUP_LD  = (SETUP_CYC  > 1) ? CW'(SETUP_CYC  - 1) : '0;
    localparam logic [CW-1:0]     PULSE_LD  = (PULSE_CYC  > 1) ? CW'(PULSE_CYC  - 1) : '0;
    localparam logic [CW-1:0]     SETTLE_LD = (SETTLE_CYC > 1) ? CW'(SETTLE_CYC - 1) : '0;
    localparam logic [WORD_W-1:0] START_W   = WORD_W'(START_ADDR);

    // VPC_* / EX_* are only reachable with the read-back check enabled.
    typedef enum logic [4:0] {
        S_IDLE, S_ACCEPT,
        S_ADDR_SETUP, S_ADDR_PULSE, S_ADDR_SETTLE,
        S_DATA_SETUP, S_DATA_PULSE, S_DATA_SETTLE,
        S_PC_SETUP, S_PC_PULSE, S_PC_SETTLE,
        S_RUN_WAIT, S_RUN, S_DONE,
        S_VPC_SETUP, S_VPC_PULSE, S_VPC_SETTLE,
        S_EX_SETUP, S_EX_PULSE, S_EX_SETTLE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_load;
    logic                tc;
    logic [WORD_W-1:0]   addr_q, data_q, next_pc_q;
    logic                last_q, pc_valid_q, run_led_q;
    logic [WORD_W:0]     words_q;
`ifdef PANEL_LOADER_VERIFY_EN
    logic                err_q;
`endif

    assign tc = (cnt_q == '0);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        if (start_i) state_d = S_ACCEPT;
            S_ACCEPT:      if (s_valid_i)
                               state_d = (pc_valid_q && s_addr_i == next_pc_q) ? S_DATA_SETUP
                                                                                : S_ADDR_SETUP;
            S_ADDR_SETUP:  if (tc) state_d = S_ADDR_PULSE;
            S_ADDR_PULSE:  if (tc) state_d = S_ADDR_SETTLE;
            S_ADDR_SETTLE: if (tc) state_d = S_DATA_SETUP;
            S_DATA_SETUP:  if (tc) state_d = S_DATA_PULSE;
            S_DATA_PULSE:  if (tc) state_d = S_DATA_SETTLE;
`ifdef PANEL_LOADER_VERIFY_EN
            S_DATA_SETTLE: if (tc) state_d = S_VPC_SETUP;
`else
            S_DATA_SETTLE: if (tc) state_d = last_q ? S_PC_SETUP : S_ACCEPT;
`endif
            S_VPC_SETUP:   if (tc) state_d = S_VPC_PULSE;
            S_VPC_PULSE:   if (tc) state_d = S_VPC_SETTLE;
            S_VPC_SETTLE:  if (tc) state_d = S_EX_SETUP;
            S_EX_SETUP:    if (tc) state_d = S_EX_PULSE;
            S_EX_PULSE:    if (tc) state_d = S_EX_SETTLE;
            S_EX_SETTLE:   if (tc) state_d = last_q ? S_PC_SETUP : S_ACCEPT;
            S_PC_SETUP:    if (tc) state_d = S_PC_PULSE;
            S_PC_PULSE:    if (tc) state_d = S_PC_SETTLE;
            S_PC_SETTLE:   if (tc) state_d = S_RUN_WAIT;
            S_RUN_WAIT:    if (run_led_i) state_d = S_RUN;
            S_RUN:         if (run_led_q && !run_led_i) state_d = S_DONE;
            S_DONE:        state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // One shared phase timer, reloaded on every state change.
    always_comb begin
        cnt_load = '0;
        case (state_d)
            S_ADDR_SETUP, S_DATA_SETUP, S_PC_SETUP, S_VPC_SETUP, S_EX_SETUP:
                cnt_load = SETUP_LD;
            S_ADDR_PULSE, S_DATA_PULSE, S_PC_PULSE, S_VPC_PULSE, S_EX_PULSE:
                cnt_load = PULSE_LD;
            S_ADDR_SETTLE, S_DATA_SETTLE, S_PC_SETTLE, S_VPC_SETTLE, S_EX_SETTLE:
                cnt_load = SETTLE_LD;
            default: cnt_load = '0;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)              cnt_q <= '0;
        else if (state_d != state_q) cnt_q <= cnt_load;
        else if (!tc)                cnt_q <= cnt_q - CW'(1);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            next_pc_q  <= '0;
            pc_valid_q <= 1'b0;
            words_q    <= '0;
            run_led_q  <= 1'b0;
`ifdef PANEL_LOADER_VERIFY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            run_led_q <= run_led_i;
            if (state_q == S_IDLE && start_i) begin
                words_q    <= '0;
                pc_valid_q <= 1'b0;
`ifdef PANEL_LOADER_VERIFY_EN
                err_q      <= 1'b0;
`endif
            end
            if (state_q == S_ACCEPT && s_valid_i) begin
                addr_q <= s_addr_i;
                data_q <= s_data_i;
                last_q <= s_last_i;
            end
            // Panel auto-increments its PC on deposit; wrap to 0 counts as sequential.
            if (state_q == S_DATA_PULSE && tc) begin
                words_q    <= words_q + (WORD_W+1)'(1);
                next_pc_q  <= addr_q + WORD_W'(1);
                pc_valid_q <= 1'b1;
            end
`ifdef PANEL_LOADER_VERIFY_EN
            if (state_q == S_EX_SETTLE && tc && led_data_i != data_q)
                err_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        sw_o   = '0;
        btnl_o = 1'b0;
        btnd_o = 1'b0;
`ifdef PANEL_LOADER_VERIFY_EN
        btnc_o = 1'b0;
`endif
        case (state_q)
            S_ADDR_SETUP, S_ADDR_SETTLE: sw_o = {1'b0, addr_q};
            S_ADDR_PULSE: begin sw_o = {1'b0, addr_q}; btnl_o = 1'b1; end
            S_DATA_SETUP, S_DATA_SETTLE: sw_o = {1'b0, data_q};
            S_DATA_PULSE: begin sw_o = {1'b0, data_q}; btnd_o = 1'b1; end
            S_VPC_SETUP, S_VPC_SETTLE, S_EX_SETUP, S_EX_SETTLE: sw_o = {1'b0, addr_q};
            S_VPC_PULSE:  begin sw_o = {1'b0, addr_q}; btnl_o = 1'b1; end
            S_EX_PULSE: begin
                sw_o = {1'b0, addr_q};
`ifdef PANEL_LOADER_VERIFY_EN
                btnc_o = 1'b1;
`endif
            end
            S_PC_SETUP, S_PC_SETTLE: sw_o = {1'b0, START_W};
            S_PC_PULSE:   begin sw_o = {1'b0, START_W}; btnl_o = 1'b1; end
            S_RUN_WAIT, S_RUN: sw_o = {1'b1, START_W};
            default: sw_o = '0;
        endcase
    end

    assign s_ready_o      = (state_q == S_ACCEPT);
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign words_loaded_o = words_q;
`ifdef PANEL_LOADER_VERIFY_EN
    assign err_mismatch_o = err_q;
`endif

endmodule

// File: tb/tb_panel_loader_seq.sv
// Directed bench for panel_loader_seq: watches the panel buttons and checks deposit order, timing and run/halt handshake.
module tb_panel_loader_seq;
    localparam int W = 12;

    logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic           s_valid = 1'b0, s_last = 1'b0, run_led = 1'b0;
    logic [W-1:0]   s_addr = '0, s_data = '0;
    logic           s_ready, btnl, btnd, busy, done, bc;
    logic [W:0]     sw, words_loaded;
`ifdef PANEL_LOADER_VERIFY_EN
    logic           btnc, err;
    logic [W-1:0]   led_data, last_dep = '0;
    assign led_data = (last_dep == 12'o7300) ? 12'o1234 : last_dep;
    assign bc = btnc;
`else
    assign bc = 1'b0;
`endif

    panel_loader_seq dut (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_addr_i(s_addr), .s_data_i(s_data),
        .s_last_i(s_last), .sw_o(sw), .btnl_o(btnl), .btnd_o(btnd), .run_led_i(run_led),
        .busy_o(busy), .done_o(done),
`ifdef PANEL_LOADER_VERIFY_EN
        .btnc_o(btnc), .led_data_i(led_data), .err_mismatch_o(err),
`endif
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;

    // Button event log: type 1=Load PC, 2=Deposit, 3=Examine; sw at rise, sw-stable cycles before rise, width.
    int ev_type[$], ev_sw[$], ev_stable[$], ev_w[$];
    int overlap_err = 0, swchg_err = 0, stable = 0, width = 0;
    logic [2:0] b_p = '0;
    logic [W:0] sw_p = '0;

    always @(negedge clk) begin
        logic [2:0] b;
        b = {bc, btnd, btnl};
        if ($countones(b) > 1) overlap_err++;
        if (b != 3'b0 && b_p != 3'b0 && sw != sw_p) swchg_err++;
        for (int k = 0; k < 3; k++)
            if (b[k] && !b_p[k]) begin
                ev_type.push_back(k + 1);
                ev_sw.push_back(int'(sw));
                ev_stable.push_back(stable);
                width = 0;
            end
        if (b != 3'b0) width++;
        if ((b_p & ~b) != 3'b0) ev_w.push_back(width);
        stable = (sw == sw_p) ? stable + 1 : 1;
`ifdef PANEL_LOADER_VERIFY_EN
        if (btnd) last_dep = sw[W-1:0];
`endif
        b_p  = b;
        sw_p = sw;
    end

    task automatic clear_log;
        ev_type.delete(); ev_sw.delete(); ev_stable.delete(); ev_w.delete();
        overlap_err = 0; swchg_err = 0;
    endtask

    task automatic do_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] d, input logic l);
        int k;
        s_addr = a; s_data = d; s_last = l; s_valid = 1'b1;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        n_assert++;
        if (k >= 3000) begin n_fail++; $display("FAIL handshake_timeout: s_ready got 0 required 1 (addr %0o)", a); end
        @(posedge clk); #1 s_valid = 1'b0;
    endtask

    task automatic wait_run_wait;
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sw[W]) break;
        end
        n_assert++;
        if (k >= 3000) begin n_fail++; $display("FAIL run_switch_timeout: sw[12] got 0 required 1"); end
    endtask

    task automatic finish_session;
        int k;
        @(posedge clk); #1 run_led = 1'b1;
        repeat (3) @(posedge clk);
        #1 run_led = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        n_assert++;
        if (k >= 100) begin n_fail++; $display("FAIL idle_timeout: busy got 1 required 0"); end
    endtask

    task automatic test_reset;
        int k;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({sw, btnl, btnd, s_ready, busy, done, words_loaded} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got sw=%0o btnl=%b btnd=%b rdy=%b busy=%b done=%b wl=%0d required all 0",
                               sw, btnl, btnd, s_ready, busy, done, words_loaded);
        end
        rst_n = 1'b1;
        do_start;
        send_word(12'o0200, 12'o7300, 1'b0);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (btnl) break;
        end
        n_assert++;
        if (k >= 200) begin n_fail++; $display("FAIL reset_btnl_wait: btnl got 0 required 1"); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (btnl !== 1'b0 || busy !== 1'b0 || sw !== '0 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_pulse: got btnl=%b busy=%b sw=%0o rdy=%b required 0 0 0 0", btnl, busy, sw, s_ready);
        end
        repeat (3) @(negedge clk);
        n_assert++;
        if (btnl !== 1'b0 || busy !== 1'b0 || sw !== '0 || words_loaded !== '0) begin
            n_fail++; $display("FAIL reset_held: got btnl=%b busy=%b sw=%0o wl=%0d required 0 0 0 0", btnl, busy, sw, words_loaded);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_log;
    endtask

    task automatic test_sequential;
        int et[5], es[5];
        et = '{1, 2, 2, 2, 1};
        es = '{'o0200, 'o7300, 'o1205, 'o7402, 'o0200};
        clear_log;
        do_start;
        send_word(12'o0200, 12'o7300, 1'b0);
        send_word(12'o0201, 12'o1205, 1'b0);
        send_word(12'o0202, 12'o7402, 1'b1);
        wait_run_wait;
        n_assert++;
        if (ev_type.size() != 5 || ev_w.size() != 5) begin
            n_fail++; $display("FAIL seq_event_count: got %0d/%0d required 5/5", ev_type.size(), ev_w.size());
        end
        for (int i = 0; i < 5 && i < ev_type.size() && i < ev_w.size(); i++) begin
            n_assert++;
            if (ev_type[i] != et[i] || ev_sw[i] != es[i] || ev_w[i] != 10 || ev_stable[i] != 10) begin
                n_fail++; $display("FAIL seq_event_%0d: got type=%0d sw=%0o width=%0d setup=%0d required type=%0d sw=%0o width=10 setup=10",
                                   i, ev_type[i], ev_sw[i], ev_w[i], ev_stable[i], et[i], es[i]);
            end
        end
        n_assert++;
        if (words_loaded !== 13'd3) begin n_fail++; $display("FAIL seq_words_loaded: got %0d required 3", words_loaded); end
        n_assert++;
        if (sw !== 13'o10200 || busy !== 1'b1) begin
            n_fail++; $display("FAIL seq_run_switch: got sw=%0o busy=%b required sw=10200 busy=1", sw, busy);
        end
        n_assert++;
        if (overlap_err != 0 || swchg_err != 0) begin
            n_fail++; $display("FAIL seq_panel_rules: got overlap=%0d sw_changes=%0d required 0 0", overlap_err, swchg_err);
        end
    endtask

    task automatic test_run;
        int dcount = 0, sw12_at_done = -1, busy_at_done = -1, busy_after = -1;
        @(posedge clk); #1 run_led = 1'b1;
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b1 || sw[W] !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL run_hold: got busy=%b sw12=%b done=%b required 1 1 0", busy, sw[W], done);
        end
        @(posedge clk); #1 run_led = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                if (dcount == 0) begin sw12_at_done = int'(sw[W]); busy_at_done = int'(busy); end
                dcount++;
            end else if (dcount > 0 && busy_after < 0) busy_after = int'(busy);
        end
        n_assert++;
        if (dcount != 1) begin n_fail++; $display("FAIL done_width: got %0d cycles required 1", dcount); end
        n_assert++;
        if (sw12_at_done != 0 || busy_at_done != 1) begin
            n_fail++; $display("FAIL done_state: got sw12=%0d busy=%0d required 0 1", sw12_at_done, busy_at_done);
        end
        n_assert++;
        if (busy_after != 0) begin n_fail++; $display("FAIL busy_after_done: got %0d required 0", busy_after); end
        n_assert++;
        if (words_loaded !== 13'd3 || sw !== '0) begin
            n_fail++; $display("FAIL idle_after_run: got wl=%0d sw=%0o required 3 0", words_loaded, sw);
        end
    endtask

    task automatic test_nonsequential;
        int et[5], es[5];
        et = '{1, 2, 1, 2, 1};
        es = '{'o0200, 'o7300, 'o0300, 'o7402, 'o0200};
        clear_log;
        do_start;
        send_word(12'o0200, 12'o7300, 1'b0);
        send_word(12'o0300, 12'o7402, 1'b1);
        wait_run_wait;
        n_assert++;
        if (ev_type.size() != 5 || ev_w.size() != 5) begin
            n_fail++; $display("FAIL nonseq_event_count: got %0d/%0d required 5/5", ev_type.size(), ev_w.size());
        end
        for (int i = 0; i < 5 && i < ev_type.size() && i < ev_w.size(); i++) begin
            n_assert++;
            if (ev_type[i] != et[i] || ev_sw[i] != es[i] || ev_w[i] != 10 || ev_stable[i] != 10) begin
                n_fail++; $display("FAIL nonseq_event_%0d: got type=%0d sw=%0o width=%0d setup=%0d required type=%0d sw=%0o width=10 setup=10",
                                   i, ev_type[i], ev_sw[i], ev_w[i], ev_stable[i], et[i], es[i]);
            end
        end
        n_assert++;
        if (words_loaded !== 13'd2) begin n_fail++; $display("FAIL nonseq_words_loaded: got %0d required 2", words_loaded); end
        finish_session;
    endtask

    task automatic test_wrap;
        int et[4], es[4];
        et = '{1, 2, 2, 1};
        es = '{'o7777, 'o1111, 'o2222, 'o0200};
        clear_log;
        do_start;
        send_word(12'o7777, 12'o1111, 1'b0);
        send_word(12'o0000, 12'o2222, 1'b1);
        wait_run_wait;
        n_assert++;
        if (ev_type.size() != 4) begin n_fail++; $display("FAIL wrap_event_count: got %0d required 4", ev_type.size()); end
        for (int i = 0; i < 4 && i < ev_type.size(); i++) begin
            n_assert++;
            if (ev_type[i] != et[i] || ev_sw[i] != es[i]) begin
                n_fail++; $display("FAIL wrap_event_%0d: got type=%0d sw=%0o required type=%0d sw=%0o",
                                   i, ev_type[i], ev_sw[i], et[i], es[i]);
            end
        end
        n_assert++;
        if (words_loaded !== 13'd2 || overlap_err != 0 || swchg_err != 0) begin
            n_fail++; $display("FAIL wrap_summary: got wl=%0d overlap=%0d sw_changes=%0d required 2 0 0", words_loaded, overlap_err, swchg_err);
        end
        finish_session;
    endtask

`ifdef PANEL_LOADER_VERIFY_EN
    task automatic test_verify;
        do_start;
        @(negedge clk);
        n_assert++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL verify_err_clear: got %b required 0", err); end
        send_word(12'o0200, 12'o7300, 1'b0);
        send_word(12'o0201, 12'o1205, 1'b1);
        wait_run_wait;
        n_assert++;
        if (err !== 1'b1 || words_loaded !== 13'd2) begin
            n_fail++; $display("FAIL verify_mismatch: got err=%b wl=%0d required 1 2", err, words_loaded);
        end
        n_assert++;
        if (overlap_err != 0 || swchg_err != 0) begin
            n_fail++; $display("FAIL verify_panel_rules: got overlap=%0d sw_changes=%0d required 0 0", overlap_err, swchg_err);
        end
        finish_session;
        n_assert++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL verify_err_sticky: got %b required 1", err); end
    endtask
`endif

    initial begin
        test_reset;
`ifdef PANEL_LOADER_VERIFY_EN
        test_verify;
`else
        test_sequential;
        test_run;
        test_nonsequential;
        test_wrap;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
